soft_bus_arbiter: RTL and testbench

- Parametrised successor to the single-core soft package interconnect.
- Shares one soft memory port among CHANNELS core-side requesters, all using the cCommand/cAddress/cData to hReady/hSignal/hData protocol.
- Registered round-robin arbitration, one outstanding memory transaction at a time, response routed back only to the granted requester.
- Sits between N Core instances and one SoftMemory inside a multi-core package.

---
 rtl/soft_bus_arbiter_if.sv | 31 +++
 rtl/soft_bus_arbiter.sv | 122 ++++++++++++
 tb/tb_soft_bus_arbiter.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/soft_bus_arbiter_if.sv
// soft_bus_arbiter_if: requester-side and memory-side signals of the soft bus arbiter.
// The arbiter uses the slave modport; the cores and the memory model use the master modport.
interface soft_bus_arbiter_if #(
   parameter int CHANNELS   = 2,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int CMD_WIDTH  = 3
);
   localparam int GW = $clog2(CHANNELS);
   logic [CHANNELS*CMD_WIDTH-1:0]  cCommand;
   logic [CHANNELS*ADDR_WIDTH-1:0] cAddress;
   logic [CHANNELS*DATA_WIDTH-1:0] cData;
   logic [CHANNELS-1:0]            hReady;
   logic [CHANNELS-1:0]            hSignal;
   logic [CHANNELS*DATA_WIDTH-1:0] hData;
   logic [CMD_WIDTH-1:0]           mCommand;
   logic [ADDR_WIDTH-1:0]          mAddress;
   logic [DATA_WIDTH-1:0]          mData;
   logic                           mReady;
   logic                           mSignal;
   logic [DATA_WIDTH-1:0]          mRdata;
   logic [GW-1:0]                  grant;
   modport master (
      output cCommand, cAddress, cData, mReady, mSignal, mRdata,
      input  hReady, hSignal, hData, mCommand, mAddress, mData, grant
   );
   modport slave (
      input  cCommand, cAddress, cData, mReady, mSignal, mRdata,
      output hReady, hSignal, hData, mCommand, mAddress, mData, grant
   );
endinterface

// File: rtl/soft_bus_arbiter.sv
// soft_bus_arbiter: registered round-robin sharing of one soft memory port among CHANNELS requesters.
// Define SOFT_ARB_TIMEOUT_EN to end a BUSY phase after TIMEOUT cycles with a faulted response.
module soft_bus_arbiter #(
   parameter int CHANNELS   = 2,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int CMD_WIDTH  = 3,
   parameter int TIMEOUT    = 255
) (
   input  logic              clock,
   input  logic              reset,
   soft_bus_arbiter_if.slave io_bus
);
   localparam int GW = $clog2(CHANNELS);
   localparam logic [1:0] S_IDLE = 2'd0, S_BUSY = 2'd1, S_RESP = 2'd2;
   logic [1:0]                     r_state;
   logic [GW-1:0]                  r_last, r_grant, w_sel, w_k;
   logic                           w_hit;
   logic [CMD_WIDTH-1:0]           r_mcmd;
   logic [ADDR_WIDTH-1:0]          r_maddr;
   logic [DATA_WIDTH-1:0]          r_mdata, r_rdata;
   logic                           r_sig;
   logic [CMD_WIDTH-1:0]           w_cmd  [CHANNELS];
   logic [ADDR_WIDTH-1:0]          w_addr [CHANNELS];
   logic [DATA_WIDTH-1:0]          w_data [CHANNELS];
   logic [CHANNELS-1:0]            w_req, w_hready, w_hsig;
   logic [CHANNELS*DATA_WIDTH-1:0] w_hdata;
`ifdef SOFT_ARB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] r_cnt;
`endif
   if (CHANNELS < 2 || CHANNELS > 8 || TIMEOUT < 1) begin : g_bad_params
      $error("soft_bus_arbiter: CHANNELS must be 2..8 and TIMEOUT at least 1");
   end
   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      assign w_cmd[g]  = io_bus.cCommand[g*CMD_WIDTH +: CMD_WIDTH];
      assign w_addr[g] = io_bus.cAddress[g*ADDR_WIDTH +: ADDR_WIDTH];
      assign w_data[g] = io_bus.cData[g*DATA_WIDTH +: DATA_WIDTH];
      assign w_req[g]  = |w_cmd[g];
   end
   // Walk last+1, last+2, ... with wrap so the previous owner is searched last.
   always_comb begin
      w_hit = 1'b0;
      w_sel = r_last;
      w_k   = r_last;
      for (int i = 0; i < CHANNELS; i++) begin
         w_k = (w_k == GW'(CHANNELS - 1)) ? '0 : w_k + 1'b1;
         if (w_req[w_k] && !w_hit) begin
            w_hit = 1'b1;
            w_sel = w_k;
         end
      end
   end
   always_comb begin
      w_hready = '0;
      w_hsig   = '0;
      w_hdata  = '0;
      for (int c = 0; c < CHANNELS; c++)
         if (r_state == S_RESP && r_grant == GW'(c)) begin
            w_hready[c] = 1'b1;
            w_hsig[c]   = r_sig;
            w_hdata[c*DATA_WIDTH +: DATA_WIDTH] = r_rdata;
         end
   end
   always_ff @(posedge clock) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_last  <= GW'(CHANNELS - 1);
         r_grant <= '0;
         r_mcmd  <= '0;
         r_maddr <= '0;
         r_mdata <= '0;
         r_sig   <= 1'b0;
         r_rdata <= '0;
`ifdef SOFT_ARB_TIMEOUT_EN
         r_cnt   <= '0;
`endif
      end else begin
         case (r_state)
            S_IDLE:
               if (w_hit) begin
                  r_mcmd  <= w_cmd[w_sel];
                  r_maddr <= w_addr[w_sel];
                  r_mdata <= w_data[w_sel];
                  r_grant <= w_sel;
                  r_state <= S_BUSY;
`ifdef SOFT_ARB_TIMEOUT_EN
                  r_cnt   <= '0;
`endif
               end
            S_BUSY:
               if (io_bus.mReady) begin
                  r_sig   <= io_bus.mSignal;
                  r_rdata <= io_bus.mRdata;
                  r_mcmd  <= '0;
                  r_state <= S_RESP;
               end
`ifdef SOFT_ARB_TIMEOUT_EN
               else if (r_cnt == TW'(TIMEOUT - 1)) begin
                  r_sig   <= 1'b1;
                  r_rdata <= '0;
                  r_mcmd  <= '0;
                  r_state <= S_RESP;
               end else
                  r_cnt <= r_cnt + 1'b1;
`endif
            S_RESP: begin
               r_last  <= r_grant;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
   assign io_bus.hReady   = w_hready;
   assign io_bus.hSignal  = w_hsig;
   assign io_bus.hData    = w_hdata;
   assign io_bus.mCommand = r_mcmd;
   assign io_bus.mAddress = r_maddr;
   assign io_bus.mData    = r_mdata;
   assign io_bus.grant    = r_grant;
endmodule

// File: tb/tb_soft_bus_arbiter.sv
// tb_soft_bus_arbiter: directed vectors on a 2-channel and a 4-channel arbiter sharing clock and reset.
// Inputs change and outputs are checked on the falling edge.
module tb_soft_bus_arbiter;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_tot = 0;
   int   n_bad = 0;
   always #5 clk = ~clk;
   soft_bus_arbiter_if #(.CHANNELS(2)) b2 ();
   soft_bus_arbiter_if #(.CHANNELS(4)) b4 ();
   soft_bus_arbiter #(.CHANNELS(2), .TIMEOUT(4)) u2 (.clock(clk), .reset(rst_n), .io_bus(b2.slave));
   soft_bus_arbiter #(.CHANNELS(4))              u4 (.clock(clk), .reset(rst_n), .io_bus(b4.slave));
   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tot++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   task automatic tick;
      @(negedge clk);
   endtask
   initial begin
      b2.cCommand = '0; b2.cAddress = '0; b2.cData = '0;
      b2.mReady = 1'b0; b2.mSignal = 1'b0; b2.mRdata = '0;
      b4.cCommand = '0; b4.cAddress = '0; b4.cData = '0;
      b4.mReady = 1'b0; b4.mSignal = 1'b0; b4.mRdata = '0;
      // all channels requesting while held in reset
      b2.cCommand = {3'd2, 3'd5};
      b2.cAddress = {32'h20, 32'h10};
      b2.cData    = {32'hB0, 32'hA0};
      b4.cCommand = {3'd4, 3'd3, 3'd2, 3'd1};
      b4.cAddress = {32'h3000, 32'h2000, 32'h1000, 32'h0};
      repeat (2) tick;
      chk("rst_resp2", {b2.hReady, b2.hSignal, b2.hData}, '0);
      chk("rst_mem2",  {b2.mCommand, b2.mAddress, b2.mData, b2.grant}, '0);
      chk("rst_hdata4", b4.hData, '0);
      chk("rst_rest4", {b4.hReady, b4.hSignal, b4.mCommand, b4.mAddress, b4.mData, b4.grant}, '0);
      rst_n = 1'b1;
      tick;
      chk("first_grant2", b2.grant, 0);
      chk("first_cmd2", b2.mCommand, 5);
      chk("first_addr2", b2.mAddress, 'h10);
      chk("first_data2", b2.mData, 'hA0);
      chk("first_grant4", b4.grant, 0);
      chk("first_cmd4", b4.mCommand, 1);
      // reset while BUSY abandons the transaction
      rst_n = 1'b0;
      b2.cCommand = '0;
      b4.cCommand = '0;
      tick;
      chk("midrst_cmd2", b2.mCommand, 0);
      chk("midrst_rdy2", b2.hReady, 0);
      chk("midrst_cmd4", b4.mCommand, 0);
      rst_n = 1'b1;
      b2.mReady = 1'b1;
      b2.mRdata = 32'h99;
      tick;
      chk("late_rdy", b2.hReady, 0);
      chk("late_cmd", b2.mCommand, 0);
      b2.mReady = 1'b0;
      // single read on channel 1, memory answers one cycle after mCommand
      b2.cCommand = {3'b001, 3'b000};
      b2.cAddress = {32'h100, 32'h0};
      b2.cData    = {32'h55, 32'h0};
      tick;
      chk("rd_addr", b2.mAddress, 'h100);
      chk("rd_cmd", b2.mCommand, 1);
      chk("rd_wdata", b2.mData, 'h55);
      chk("rd_grant", b2.grant, 1);
      chk("rd_rdy_k1", b2.hReady, 0);
      tick;
      chk("rd_rdy_k2", b2.hReady, 0);
      chk("rd_cmd_k2", b2.mCommand, 1);
      b2.mReady = 1'b1;
      b2.mRdata = 32'hDEADBEEF;
      tick;
      chk("rd_rdy_k3", b2.hReady, 2'b10);
      chk("rd_hdata", b2.hData, {32'hDEADBEEF, 32'h0});
      chk("rd_hsig", b2.hSignal, 0);
      chk("rd_cmd_clr", b2.mCommand, 0);
      b2.mReady = 1'b0;
      b2.cCommand = '0;
      tick;
      chk("rd_pulse", b2.hReady, 0);
      chk("rd_hdata_clr", b2.hData, 0);
      // fault response on channel 0
      b2.cCommand = {3'b000, 3'b100};
      b2.cAddress = {32'h0, 32'h200};
      tick;
      chk("flt_grant", b2.grant, 0);
      chk("flt_addr", b2.mAddress, 'h200);
      b2.mReady  = 1'b1;
      b2.mSignal = 1'b1;
      b2.mRdata  = 32'h77;
      tick;
      chk("flt_rdy", b2.hReady, 2'b01);
      chk("flt_sig", b2.hSignal, 2'b01);
      chk("flt_hdata", b2.hData, {32'h0, 32'h77});
      b2.mReady  = 1'b0;
      b2.mSignal = 1'b0;
      b2.cCommand = '0;
      tick;
      chk("flt_sig_drop", b2.hSignal, 0);
      chk("flt_rdy_drop", b2.hReady, 0);
      // memory never answers channel 1
      b2.cCommand = {3'd6, 3'd0};
      tick;
      chk("to_grant", b2.grant, 1);
      chk("to_cmd1", b2.mCommand, 6);
      repeat (3) tick;
      chk("to_cmd4", b2.mCommand, 6);
      chk("to_rdy4", b2.hReady, 0);
      tick;
`ifdef SOFT_ARB_TIMEOUT_EN
      chk("to_cmd_clr", b2.mCommand, 0);
      chk("to_rdy", b2.hReady, 2'b10);
      chk("to_sig", b2.hSignal, 2'b10);
      chk("to_hdata", b2.hData, 0);
      b2.cCommand = '0;
      tick;
      b2.mReady = 1'b1;
      tick;
      chk("to_late_rdy", b2.hReady, 0);
      chk("to_late_cmd", b2.mCommand, 0);
      b2.mReady = 1'b0;
`else
      chk("no_to_cmd", b2.mCommand, 6);
      chk("no_to_rdy", b2.hReady, 0);
      b2.mReady = 1'b1;
      b2.mRdata = 32'h66;
      tick;
      chk("no_to_resp", b2.hReady, 2'b10);
      chk("no_to_hdata", b2.hData, {32'h66, 32'h0});
      b2.mReady = 1'b0;
      b2.cCommand = '0;
      tick;
`endif
      // four channels requesting continuously, memory answering in one cycle
      b4.cCommand = {3'd4, 3'd3, 3'd2, 3'd1};
      for (int i = 0; i < 5; i++) begin
         tick;
         chk("rr_grant", b4.grant, i % 4);
         chk("rr_cmd", b4.mCommand, i % 4 + 1);
         chk("rr_addr", b4.mAddress, (i % 4) * 'h1000);
         b4.mReady = 1'b1;
         b4.mRdata = 32'hC0 + i;
         tick;
         chk("rr_hready", b4.hReady, 4'b1 << (i % 4));
         chk("rr_hdata", b4.hData, 128'(32'hC0 + i) << (32 * (i % 4)));
         b4.mReady = 1'b0;
         tick;
      end
      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end
endmodule
